hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/load_use_detect.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/stall controller:
// FSM states, hazard classes and the per-cycle priority encoder.
package hazard_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        HZ_NONE      = 3'd0,
        HZ_LOADUSE   = 3'd1,
        HZ_MDU_STALL = 3'd2,
        HZ_MDU_START = 3'd3,
        HZ_BRANCH    = 3'd4,
        HZ_FREEZE    = 3'd5
    } hazard_t;

    // Highest first: memory freeze, branch, MDU, load-use.
    function automatic hazard_t pick_hazard(
        input logic freeze,
        input logic branch,
        input logic mdu_start,
        input logic mdu_stall,
        input logic load_use
    );
        hazard_t h;
        h = HZ_NONE;
        if (freeze)
            h = HZ_FREEZE;
        else if (branch)
            h = HZ_BRANCH;
        else if (mdu_start)
            h = HZ_MDU_START;
        else if (mdu_stall)
            h = HZ_MDU_STALL;
        else if (load_use)
            h = HZ_LOADUSE;
        return h;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose rd feeds
// a source register of the instruction in ID.
module load_use_detect (
    input  logic       memread,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    output logic       hit
);

    logic match1;
    logic match2;

    assign match1 = uses_rs1 && (rd == rs1);
    assign match2 = uses_rs2 && (rd == rs2);
    assign hit    = memread && (rd != 5'd0) && (match1 || match2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles and flushes
// for load-use, branch, MDU and data-memory wait hazards.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_MAX_CYCLES = 64,
    parameter int CNT_W          = 32,
    parameter int TMR_W          = 7
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic [4:0]       in_ifid_rs1,
    input  logic [4:0]       in_ifid_rs2,
    input  logic             in_ifid_uses_rs1,
    input  logic             in_ifid_uses_rs2,
    input  logic             in_idex_memread,
    input  logic [4:0]       in_idex_rd,
    input  logic             in_idex_mdu_valid,
    input  logic             in_mdu_done,
    input  logic             in_ex_branch_taken,
    input  logic             in_exmem_memaccess,
    input  logic             in_dmem_ready,
    input  logic             in_stall_cnt_clr,
    output logic             out_pc_write,
    output logic             out_ifid_write,
    output logic             out_ifid_flush,
    output logic             out_idex_write,
    output logic             out_idex_bubble,
    output logic             out_exmem_write,
    output logic             out_exmem_bubble,
    output logic             out_memwb_write,
    output logic             out_mdu_start,
    output logic             out_mdu_timeout,
    output logic [CNT_W-1:0] out_stall_cycles
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MDU_MAX_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nx;
    logic             timeout_set;
    logic             freeze;
    logic             lu_hit;
    logic             in_run;
    logic             at_last;
    hazard_t          hazard;

    load_use_detect u_lud (
        .memread  (in_idex_memread),
        .rd       (in_idex_rd),
        .rs1      (in_ifid_rs1),
        .rs2      (in_ifid_rs2),
        .uses_rs1 (in_ifid_uses_rs1),
        .uses_rs2 (in_ifid_uses_rs2),
        .hit      (lu_hit)
    );

    assign freeze  = in_exmem_memaccess && !in_dmem_ready;
    assign in_run  = (state == ST_RUN);
    assign at_last = (timer == TMR_LAST);

    assign hazard = pick_hazard(
        freeze,
        in_ex_branch_taken,
        in_run && in_idex_mdu_valid,
        !in_run && !in_mdu_done && !at_last,
        in_run && lu_hit
    );

    // Next state: a freeze holds the FSM but the wait timer keeps aging.
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        timeout_set = 1'b0;
        case (state)
            ST_RUN: begin
                if (!freeze && !in_ex_branch_taken && in_idex_mdu_valid) begin
                    state_nx = ST_MDU_WAIT;
                    timer_nx = '0;
                end
            end
            ST_MDU_WAIT: begin
                if (freeze) begin
                    if (!at_last)
                        timer_nx = timer + TMR_W'(1);
                end else if (in_mdu_done) begin
                    state_nx = ST_RUN;
                end else if (at_last) begin
                    state_nx    = ST_RUN;
                    timeout_set = 1'b1;
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        out_pc_write     = 1'b1;
        out_ifid_write   = 1'b1;
        out_ifid_flush   = 1'b0;
        out_idex_write   = 1'b1;
        out_idex_bubble  = 1'b0;
        out_exmem_write  = 1'b1;
        out_exmem_bubble = 1'b0;
        out_memwb_write  = 1'b1;
        out_mdu_start    = 1'b0;
        unique case (hazard)
            HZ_FREEZE: begin
                out_pc_write    = 1'b0;
                out_ifid_write  = 1'b0;
                out_idex_write  = 1'b0;
                out_exmem_write = 1'b0;
                out_memwb_write = 1'b0;
            end
            HZ_BRANCH: begin
                out_ifid_flush  = 1'b1;
                out_idex_bubble = 1'b1;
            end
            HZ_MDU_START, HZ_MDU_STALL: begin
                out_pc_write     = 1'b0;
                out_ifid_write   = 1'b0;
                out_idex_write   = 1'b0;
                out_exmem_bubble = 1'b1;
                out_mdu_start    = (hazard == HZ_MDU_START);
            end
            HZ_LOADUSE: begin
                out_pc_write    = 1'b0;
                out_ifid_write  = 1'b0;
                out_idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= ST_RUN;
            timer           <= '0;
            out_mdu_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (timeout_set)
                out_mdu_timeout <= 1'b1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            out_stall_cycles <= '0;
        else if (in_stall_cnt_clr)
            out_stall_cycles <= '0;
        else if (!out_pc_write && (out_stall_cycles != '1))
            out_stall_cycles <= out_stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios
// followed by random traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;

    localparam int MAXC = 8;

    // {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, exmem_bubble, memwb_w, mdu_start}
    localparam logic [8:0] C_DEF   = 9'b110101010;
    localparam logic [8:0] C_LU    = 9'b000111010;
    localparam logic [8:0] C_BR    = 9'b111111010;
    localparam logic [8:0] C_STALL = 9'b000001110;
    localparam logic [8:0] C_START = 9'b000001111;
    localparam logic [8:0] C_FRZ   = 9'b000000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        uses_rs1, uses_rs2, memread;
    logic        mdu_valid, mdu_done, br_taken;
    logic        memaccess, dmem_ready, cnt_clr;
    logic        pc_w, ifid_w, ifid_f, idex_w, idex_b;
    logic        exmem_w, exmem_b, memwb_w, mdu_start, mdu_tmo;
    logic [31:0] stall_cnt;
    logic [8:0]  ctl;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit     m_busy;
    int     m_age;
    bit     m_tmo;
    longint m_cnt;

    always #5 clk = ~clk;

    assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_b,
                  exmem_w, exmem_b, memwb_w, mdu_start};

    hazard_stall_ctrl #(
        .MDU_MAX_CYCLES (MAXC),
        .CNT_W          (32),
        .TMR_W          (7)
    ) dut (
        .in_clk             (clk),
        .in_rst_n           (rst_n),
        .in_ifid_rs1        (rs1),
        .in_ifid_rs2        (rs2),
        .in_ifid_uses_rs1   (uses_rs1),
        .in_ifid_uses_rs2   (uses_rs2),
        .in_idex_memread    (memread),
        .in_idex_rd         (rd),
        .in_idex_mdu_valid  (mdu_valid),
        .in_mdu_done        (mdu_done),
        .in_ex_branch_taken (br_taken),
        .in_exmem_memaccess (memaccess),
        .in_dmem_ready      (dmem_ready),
        .in_stall_cnt_clr   (cnt_clr),
        .out_pc_write       (pc_w),
        .out_ifid_write     (ifid_w),
        .out_ifid_flush     (ifid_f),
        .out_idex_write     (idex_w),
        .out_idex_bubble    (idex_b),
        .out_exmem_write    (exmem_w),
        .out_exmem_bubble   (exmem_b),
        .out_memwb_write    (memwb_w),
        .out_mdu_start      (mdu_start),
        .out_mdu_timeout    (mdu_tmo),
        .out_stall_cycles   (stall_cnt)
    );

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0;
        uses_rs1 = 0; uses_rs2 = 0; memread = 0;
        mdu_valid = 0; mdu_done = 0; br_taken = 0;
        memaccess = 0; dmem_ready = 1; cnt_clr = 0;
    endtask

    // advance one clock, drive point is 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic set_lw_hit();
        memread = 1; rd = 5; rs1 = 5; uses_rs1 = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #2;
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_DEF);
        end
        checks++;
        if (stall_cnt !== 32'd0 || mdu_tmo !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs cnt=%0d tmo=%b exp cnt=0 tmo=0", stall_cnt, mdu_tmo);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw_hit();
        #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_LU);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== C_DEF || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL lu_after got=%b cnt=%0d exp=%b cnt=1", ctl, stall_cnt, C_DEF);
        end
        memread = 1; rd = 0; rs1 = 0; uses_rs1 = 1;
        #1;
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL lu_rd0 got=%b exp=%b", ctl, C_DEF);
        end
        rd = 7; rs2 = 7; uses_rs2 = 0; rs1 = 3;
        #1;
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL lu_unused_rs2 got=%b exp=%b", ctl, C_DEF);
        end
        uses_rs2 = 1;
        #1;
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, C_LU);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++; $display("FAIL lu_count got=%0d exp=2", stall_cnt);
        end
    endtask

    task automatic test_branch_vs_loaduse();
        do_reset();
        set_lw_hit();
        br_taken = 1;
        mdu_valid = 1;
        #1;
        checks++;
        if (ctl !== C_BR) begin
            errors++; $display("FAIL br_prio got=%b exp=%b", ctl, C_BR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd0 || ctl !== C_DEF) begin
            errors++;
            $display("FAIL br_after cnt=%0d ctl=%b exp cnt=0 ctl=%b", stall_cnt, ctl, C_DEF);
        end
    endtask

    task automatic test_mdu();
        logic [8:0] exp;
        do_reset();
        mdu_valid = 1;
        for (int c = 1; c <= 5; c++) begin
            mdu_done = (c == 5);
            exp = (c == 1) ? C_START : (c == 5) ? C_DEF : C_STALL;
            #1;
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL mdu_cyc%0d got=%b exp=%b", c, ctl, exp);
            end
            tick();
        end
        idle();
        set_lw_hit();
        #1;
        checks++;
        if (ctl !== C_LU || stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL mdu_back_run got=%b cnt=%0d exp=%b cnt=4", ctl, stall_cnt, C_LU);
        end
        tick();
        idle();
    endtask

    task automatic test_timeout();
        logic [8:0] exp;
        do_reset();
        mdu_valid = 1;
        tick();
        for (int w = 1; w <= MAXC; w++) begin
            exp = (w == MAXC) ? C_DEF : C_STALL;
            #1;
            checks++;
            if (ctl !== exp || mdu_tmo !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait%0d got=%b tmo=%b exp=%b tmo=0", w, ctl, mdu_tmo, exp);
            end
            tick();
        end
        mdu_valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (mdu_tmo !== 1'b1 || ctl !== C_DEF) begin
                errors++;
                $display("FAIL tmo_sticky%0d tmo=%b ctl=%b exp tmo=1 ctl=%b", k, mdu_tmo, ctl, C_DEF);
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 32'd8) begin
            errors++; $display("FAIL tmo_count got=%0d exp=8", stall_cnt);
        end
    endtask

    task automatic test_freeze_in_wait();
        do_reset();
        mdu_valid = 1;
        tick();
        tick();
        memaccess = 1; dmem_ready = 0;
        for (int f = 0; f < 3; f++) begin
            #1;
            checks++;
            if (ctl !== C_FRZ) begin
                errors++; $display("FAIL frz_cyc%0d got=%b exp=%b", f, ctl, C_FRZ);
            end
            tick();
        end
        memaccess = 0; dmem_ready = 1;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++; $display("FAIL frz_still_wait got=%b exp=%b", ctl, C_STALL);
        end
        tick();
        mdu_done = 1;
        #1;
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL frz_release got=%b exp=%b", ctl, C_DEF);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 32'd6 || mdu_tmo !== 1'b0) begin
            errors++;
            $display("FAIL frz_count cnt=%0d tmo=%b exp cnt=6 tmo=0", stall_cnt, mdu_tmo);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mdu_valid = 1;
        tick();
        tick();
        #2;
        idle();
        rst_n = 0;
        #1;
        checks++;
        if (ctl !== C_DEF || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got=%b cnt=%0d exp=%b cnt=0", ctl, stall_cnt, C_DEF);
        end
        tick();
        rst_n = 1;
        tick();
        checks++;
        if (ctl !== C_DEF || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_after got=%b cnt=%0d exp=%b cnt=0", ctl, stall_cnt, C_DEF);
        end
    endtask

    task automatic test_cnt_clr();
        do_reset();
        set_lw_hit();
        tick();
        tick();
        tick();
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++; $display("FAIL clr_pre got=%0d exp=3", stall_cnt);
        end
        cnt_clr = 1;
        tick();
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL clr_with_stall got=%0d exp=0", stall_cnt);
        end
        cnt_clr = 0;
        tick();
        idle();
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL clr_resume got=%0d exp=1", stall_cnt);
        end
    endtask

    function automatic logic [8:0] model_ctl();
        bit lu;
        lu = memread && rd != 0 &&
             ((uses_rs1 && rd == rs1) || (uses_rs2 && rd == rs2));
        if (memaccess && !dmem_ready) return C_FRZ;
        if (br_taken)                 return C_BR;
        if (m_busy)
            return (mdu_done || m_age == MAXC - 1) ? C_DEF : C_STALL;
        if (mdu_valid)                return C_START;
        if (lu)                       return C_LU;
        return C_DEF;
    endfunction

    task automatic model_step(input logic [8:0] exp);
        bit frz;
        frz = memaccess && !dmem_ready;
        if (m_busy) begin
            if (frz) begin
                if (m_age < MAXC - 1) m_age++;
            end else if (mdu_done) begin
                m_busy = 0;
            end else if (m_age == MAXC - 1) begin
                m_busy = 0;
                m_tmo  = 1;
            end else begin
                m_age++;
            end
        end else if (!frz && !br_taken && mdu_valid) begin
            m_busy = 1;
            m_age  = 0;
        end
        if (cnt_clr)
            m_cnt = 0;
        else if (!exp[8] && m_cnt < 64'hFFFF_FFFF)
            m_cnt++;
    endtask

    task automatic test_random();
        logic [8:0] exp;
        do_reset();
        m_busy = 0; m_age = 0; m_tmo = 0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            rd       = 5'($urandom_range(0, 3));
            uses_rs1 = 1'($urandom_range(0, 1));
            uses_rs2 = 1'($urandom_range(0, 1));
            memread  = ($urandom_range(0, 99) < 40);
            memaccess = ($urandom_range(0, 99) < 30);
            dmem_ready = ($urandom_range(0, 99) < 60);
            cnt_clr  = ($urandom_range(0, 99) < 4);
            if (m_busy) begin
                mdu_valid = 1;
                br_taken  = 0;
                mdu_done  = ($urandom_range(0, 99) < 15);
            end else begin
                mdu_valid = ($urandom_range(0, 99) < 15);
                br_taken  = ($urandom_range(0, 99) < 15);
                mdu_done  = 0;
            end
            #1;
            exp = model_ctl();
            checks++;
            if (ctl !== exp) begin
                errors++; $display("FAIL rnd_ctl n=%0d got=%b exp=%b", n, ctl, exp);
            end
            checks++;
            if (stall_cnt !== 32'(m_cnt) || mdu_tmo !== m_tmo) begin
                errors++;
                $display("FAIL rnd_regs n=%0d cnt=%0d tmo=%b exp cnt=%0d tmo=%b",
                         n, stall_cnt, mdu_tmo, m_cnt, m_tmo);
            end
            model_step(exp);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        #1;
        test_reset();
        test_load_use();
        test_branch_vs_loaduse();
        test_mdu();
        test_timeout();
        test_freeze_in_wait();
        test_reset_mid_wait();
        test_cnt_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
